// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out LSB first on device clock falling edges, appends
// odd parity and a stop bit, then checks the device ack.
// Optional build macro PS2_TX_RETRY_EN: a failed frame is silently retried once
// with the same byte before tx_error is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_ACK, S_WAITREL, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
`endif

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fe;
  logic tmo_active;
  logic fail;

  assign fe         = clk_prev_q & ~clk_sync_q;
  assign tmo_active = (state_q == S_REQ) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                      (state_q == S_ACK) || (state_q == S_WAITREL);

  // Two-flop synchronisers for the raw bus lines plus a delayed clock for edge detect.
  // NOTE: the synchroniser flops reset to 1 (idle bus level) so no false falling edge
  // is seen as reset releases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    ready_d   = ready_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    if (tmo_active) tmo_cnt_d = tmo_cnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          data_d    = tx_data;
          parity_d  = ~^tx_data;
          ready_d   = 1'b0;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      S_REQ: begin
        if (fe) begin
          bit_idx_d = 3'd0;
          dat_oe_d  = ~data_q[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fe) begin
          if (bit_idx_q == 3'd7) begin
            dat_oe_d = ~parity_q;
            state_d  = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            dat_oe_d  = ~data_q[bit_idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (fe) begin
          dat_oe_d = 1'b0;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          if (!dat_sync_q) state_d = S_WAITREL;
          else             fail    = 1'b1;
        end
      end
      S_WAITREL: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout overrides whatever the frame logic decided this cycle.
    if (tmo_active && (tmo_cnt_q == TMO_LAST)) fail = 1'b1;

    if (fail) begin
      done_d   = 1'b0;
      dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        clk_oe_d  = 1'b1;
        inh_cnt_d = '0;
        state_d   = S_INHIBIT;
      end else begin
        clk_oe_d = 1'b0;
        error_d  = 1'b1;
        state_d  = S_ERR;
      end
`else
      clk_oe_d = 1'b0;
      error_d  = 1'b1;
      state_d  = S_ERR;
`endif
    end
  end

  // Frame sequencer state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines, a
// scoreboard of expected outcomes/frames, and a monitor that checks each
// done/error pulse and each request-to-send against the reference model.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 2000;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; bit ok; int n_cap; bit chk_lat; } exp_t;
  typedef struct { logic [7:0] data; bit par; bit stop; } cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];
  int   total = 0;
  int   bad = 0;
  int   resolved = 0;
  int   req_cyc = 0;
  int   dev_mode = 0;
  bit   nacked_once = 0;
  int   dev_fe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference parity: set when the byte carries an even number of ones.
  function automatic bit ref_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (((d >> i) & 8'h01) != 0) ones++;
    return (ones % 2) == 0;
  endfunction

  // Behavioural device: waits for request-to-send, generates 11 clocks,
  // samples data on each rising edge, acks (or not) per dev_mode.
  // Modes: 0 ack, 1 never clock, 2 nack first frame only, 3 abort after 5th fall.
  initial begin : device
    cap_t c;
    bit   nack;
    forever begin
      do @(negedge clk); while (ps2_clk_oe !== 1'b1);
      do @(negedge clk); while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1));
      if (dev_mode == 1) continue;
      nack = (dev_mode == 2) && !nacked_once;
      if (nack) nacked_once = 1;
      repeat (H) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
        dev_clk_low = 1'b1;
        dev_fe_cnt  = k;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        if (dev_mode == 3 && k == 5) break;
        @(negedge clk);
        if (k <= 8) c.data[k-1] = ps2_dat_in;
        else if (k == 9) c.par = ps2_dat_in;
        else if (k == 10) begin
          c.stop = ps2_dat_in;
          cap_q.push_back(c);
          if (!nack) dev_dat_low = 1'b1;
        end
        repeat (H - 1) @(negedge clk);
      end
      dev_dat_low = 1'b0;
      dev_fe_cnt  = 0;
    end
  end

  // Monitor: checks each request-to-send and pops the scoreboard on every pulse.
  initial begin : monitor
    int   run = 0;
    bit   prev_oe = 0;
    exp_t e;
    cap_t c;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        run = 0;
        prev_oe = 0;
      end else begin
        if (ps2_clk_oe) run++;
        if (prev_oe && !ps2_clk_oe) begin
          check("inhibit_len", run, INH);
          check("ready_low_in_frame", tx_ready, 1'b0);
          check("start_bit_drive", ps2_dat_oe, 1'b1);
          req_cyc = cyc;
        end
        if (!ps2_clk_oe) run = 0;
        if (tx_done || tx_error) begin
          check("done_error_exclusive", tx_done & tx_error, 1'b0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {tx_done, tx_error}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check("outcome_done", tx_done, e.ok);
            check("outcome_error", tx_error, !e.ok);
            if (tx_done) check("ready_back", tx_ready, 1'b1);
            if (tx_error) check("oe_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
            if (e.chk_lat) check("timeout_latency", cyc - req_cyc, TMO);
            check("frames_seen", cap_q.size(), e.n_cap);
            for (int i = 0; i < e.n_cap && cap_q.size() > 0; i++) begin
              c = cap_q.pop_front();
              check("frame_data", c.data, e.data);
              check("frame_parity", c.par, ref_parity(e.data));
              check("frame_stop", c.stop, 1'b1);
            end
            resolved++;
          end
        end
        prev_oe = ps2_clk_oe;
      end
    end
  end

  task automatic wait_resolved(input int target);
    int n = 0;
    while (resolved < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("resolved_in_time", resolved >= target, 1'b1);
  endtask

  task automatic push_exp(input logic [7:0] d, input bit ok, input int ncap, input bit lat);
    exp_t e;
    e.data = d; e.ok = ok; e.n_cap = ncap; e.chk_lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit ok, input int ncap,
                      input bit lat);
    int target;
    int n = 0;
    dev_mode = mode;
    nacked_once = 0;
    if (mode != 3) push_exp(d, ok, ncap, lat);
    target = resolved + 1;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("ready_drop", tx_ready, 1'b0);
    if (mode != 3) wait_resolved(target);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    int target;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, 0, 1, 1, 0);
    send(8'h07, 0, 1, 1, 0);
    send(8'hFF, 1, 0, 0, 1);
`ifdef PS2_TX_RETRY_EN
    send(8'hA5, 2, 1, 2, 0);
`else
    send(8'hA5, 2, 0, 1, 0);
`endif

    // Reset mid-frame after the 5th device falling edge.
    send(8'hED, 3, 0, 0, 0);
    n = 0;
    while (dev_fe_cnt != 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("fifth_edge_reached", dev_fe_cnt, 5);
    repeat (4) @(posedge clk);
    check("mid_frame_dat_oe", ps2_dat_oe, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 1'b0);
    check("async_rst_dat_oe", ps2_dat_oe, 1'b0);
    check("async_rst_pulses", {tx_done, tx_error}, 2'b00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1'b1);
    repeat (3 * H) @(negedge clk);
    send(8'hF4, 0, 1, 1, 0);

    // tx_valid held high across two bytes.
    push_exp(8'hED, 1, 1, 0);
    push_exp(8'h02, 1, 1, 0);
    dev_mode = 0;
    target = resolved + 2;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hED;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_data = 8'h02;
    n = 0;
    while (resolved < target - 1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("second_accept", tx_ready, 1'b0);
    tx_valid = 1'b0;
    wait_resolved(target);

    // Randomised bytes with an acking device, then one with a nack.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send(d, 0, 1, 1, 0);
    end
    d = 8'($urandom);
`ifdef PS2_TX_RETRY_EN
    send(d, 2, 1, 2, 0);
`else
    send(d, 2, 0, 1, 0);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
